// File: rtl/dev_tape_emulator_pkg.sv
// Shared constants and FSM state encodings for the tape reader/punch emulator.
package dev_tape_emulator_pkg;
  localparam int CHAR_W = 5;

  typedef enum logic [1:0] {I_IDLE, I_VAL, I_GAP} in_state_t;
  typedef enum logic       {O_IDLE, O_ACK}        out_state_t;
endpackage

// File: rtl/dev_tape_emulator_sync_fifo_flush.sv
// Synchronous FIFO with occupancy count and a flush that can optionally keep the head entry.
module sync_fifo_flush #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  input  logic                         keep_head,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop, keep;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  // A head popped in the flush cycle is gone, so there is nothing left to keep.
  assign keep    = keep_head & ~do_pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (flush) begin
        wr_ptr <= rd_ptr + AW'(do_pop) + AW'(keep);
        count  <= CW'(keep);
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/dev_tape_emulator.sv
// Tape reader/punch emulator: feeds host characters to the core over a four-phase
// input handshake and captures core output characters into a one-entry host buffer.
module dev_tape_emulator
  import dev_tape_emulator_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CHAR_GAP   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              dev_input_rdy,
  output logic                              dev_input_val,
  output logic [CHAR_W-1:0]                 dev_input_data,
  input  logic                              dev_output_rdy,
  input  logic [CHAR_W-1:0]                 dev_output_data,
  output logic                              dev_output_ack,
  input  logic                              host_in_valid,
  input  logic [CHAR_W-1:0]                 host_in_data,
  output logic                              host_in_ready,
  input  logic                              host_flush,
  output logic                              host_out_valid,
  output logic [CHAR_W-1:0]                 host_out_data,
  input  logic                              host_out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int GW = (CHAR_GAP > 0) ? $clog2(CHAR_GAP+1) : 1;

  in_state_t          istate;
  out_state_t         ostate;
  logic [GW-1:0]      gap_cnt;
  logic [CHAR_W-1:0]  fifo_head;
  logic               fifo_full, fifo_empty, fifo_pop;

  assign host_in_ready = ~fifo_full & ~host_flush;
  assign fifo_pop      = (istate == I_VAL) & ~dev_input_rdy;

  sync_fifo_flush #(.DEPTH(FIFO_DEPTH), .W(CHAR_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (host_in_valid & host_in_ready),
    .push_data (host_in_data),
    .pop       (fifo_pop),
    .flush     (host_flush),
    .keep_head (istate == I_VAL),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      istate         <= I_IDLE;
      gap_cnt        <= '0;
      dev_input_val  <= 1'b0;
      dev_input_data <= '0;
    end else begin
      case (istate)
        I_IDLE: if (dev_input_rdy && !fifo_empty && gap_cnt == '0) begin
          istate         <= I_VAL;
          dev_input_val  <= 1'b1;
          dev_input_data <= fifo_head;
        end
        I_VAL: if (!dev_input_rdy) begin
          dev_input_val  <= 1'b0;
          dev_input_data <= '0;
          if (CHAR_GAP == 0) istate <= I_IDLE;
          else begin
            gap_cnt <= GW'(CHAR_GAP);
            istate  <= I_GAP;
          end
        end
        I_GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) istate <= I_IDLE;
        end
        default: istate <= I_IDLE;
      endcase
    end
  end

  // Capture waits for an empty buffer, which stalls the core's output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      ostate         <= O_IDLE;
      dev_output_ack <= 1'b0;
      host_out_valid <= 1'b0;
      host_out_data  <= '0;
    end else begin
      if (host_out_ready) host_out_valid <= 1'b0;
      case (ostate)
        O_IDLE: if (dev_output_rdy && !host_out_valid) begin
          host_out_data  <= dev_output_data;
          host_out_valid <= 1'b1;
          dev_output_ack <= 1'b1;
          ostate         <= O_ACK;
        end
        O_ACK: if (!dev_output_rdy) begin
          dev_output_ack <= 1'b0;
          ostate         <= O_IDLE;
        end
        default: ostate <= O_IDLE;
      endcase
    end
  end
endmodule
